// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the PQ control-SPR file: addresses, sizes, update strobes.
package otbn_pq_pkg;

  localparam int PqctrlsprNumWidth = 8;
  localparam int PqKeccakDim       = 5;
  localparam int PqRcCount         = 24;

  typedef enum logic [PqctrlsprNumWidth-1:0] {
    PqCtrlSprM        = 8'h00,
    PqCtrlSprJ2       = 8'h01,
    PqCtrlSprJ        = 8'h02,
    PqCtrlSprIdx0     = 8'h03,
    PqCtrlSprIdx1     = 8'h04,
    PqCtrlSprMode     = 8'h05,
    PqCtrlSprX        = 8'h06,
    PqCtrlSprY        = 8'h07,
    PqCtrlSprOmegaIdx = 8'h60,
    PqCtrlSprPsiIdx   = 8'h70,
    PqCtrlSprRcIdx    = 8'hB0
  } pqctrlspr_e;

  typedef struct packed {
    logic sl_m;
    logic sl_j2;
    logic inc_j;
    logic inc_idx;
    logic set_idx;
    logic inc_x;
    logic inc_y;
    logic rc_idx_inc;
    logic omega_idx_inc;
    logic psi_idx_inc;
  } pqctrlspr_upd_t;

endpackage

// File: rtl/otbn_pq_ctrlspr_idx_cnt.sv
// Wrapping index counter (0..Modulus-1); clear beats load beats increment.
// Value visible one cycle after the enabling edge; no backpressure.
module otbn_pq_ctrlspr_idx_cnt #(
  parameter int Width   = 3,
  parameter int Modulus = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] CntMax = Width'(Modulus - 1);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i) begin
      // A loaded out-of-range value also wraps straight back to zero.
      cnt_d = (cnt_q >= CntMax) ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/otbn_pq_ctrlspr_file.sv
// PQ control-SPR file: rd/wr/read-set access plus loop-index auto-updates; reads are combinational,
// writes land on the next edge; no backpressure. Keccak registers exist only with OTBN_PQ_KECCAK_EN.
module otbn_pq_ctrlspr_file
  import otbn_pq_pkg::*;
#(
  parameter int PQLEN = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         insn_valid_i,
  input  logic                         sec_wipe_i,
  input  logic [PqctrlsprNumWidth-1:0] ispr_addr_i,
  input  logic [PQLEN-1:0]             ispr_wdata_i,
  input  logic                         ispr_rd_insn_i,
  input  logic                         ispr_wr_insn_i,
  input  logic                         ispr_rs_insn_i,
  input  logic                         sl_m_i,
  input  logic                         sl_j2_i,
  input  logic                         inc_j_i,
  input  logic                         inc_idx_i,
  input  logic                         set_idx_i,
  input  logic                         inc_x_i,
  input  logic                         inc_y_i,
  input  logic                         rc_idx_inc_i,
  input  logic                         omega_idx_inc_i,
  input  logic                         psi_idx_inc_i,
  output logic [PQLEN-1:0]             ispr_rdata_o,
  output logic                         ispr_err_o,
  output logic [PQLEN-1:0]             m_o,
  output logic [PQLEN-1:0]             j2_o,
  output logic [PQLEN-1:0]             j_o,
  output logic [PQLEN-1:0]             idx0_o,
  output logic [PQLEN-1:0]             idx1_o,
  output logic [PQLEN-1:0]             mode_o,
  output logic [2:0]                   x_o,
  output logic [2:0]                   y_o,
  output logic [2:0]                   omega_idx_o,
  output logic [2:0]                   psi_idx_o,
  output logic [4:0]                   rc_idx_o
);

  pqctrlspr_upd_t upd;
  logic [PQLEN-1:0] m_d, m_q, j2_d, j2_q, j_d, j_q;
  logic [PQLEN-1:0] idx0_d, idx0_q, idx1_d, idx1_q, mode_d, mode_q;
  logic [PQLEN-1:0] rd_old, wval;
  logic sel_m, sel_j2, sel_j, sel_idx0, sel_idx1, sel_mode, sel_omega, sel_psi;
  logic sel_x, sel_y, sel_rc;
  logic mapped, req_any, req_multi, wr_en;

  assign upd = insn_valid_i ? pqctrlspr_upd_t'({sl_m_i, sl_j2_i, inc_j_i, inc_idx_i, set_idx_i,
                                                inc_x_i, inc_y_i, rc_idx_inc_i, omega_idx_inc_i,
                                                psi_idx_inc_i}) : '0;

  always_comb begin
    sel_m     = 1'b0;
    sel_j2    = 1'b0;
    sel_j     = 1'b0;
    sel_idx0  = 1'b0;
    sel_idx1  = 1'b0;
    sel_mode  = 1'b0;
    sel_omega = 1'b0;
    sel_psi   = 1'b0;
    sel_x     = 1'b0;
    sel_y     = 1'b0;
    sel_rc    = 1'b0;
    rd_old    = '0;
    case (ispr_addr_i)
      PqCtrlSprM:        begin sel_m     = 1'b1; rd_old = m_q;    end
      PqCtrlSprJ2:       begin sel_j2    = 1'b1; rd_old = j2_q;   end
      PqCtrlSprJ:        begin sel_j     = 1'b1; rd_old = j_q;    end
      PqCtrlSprIdx0:     begin sel_idx0  = 1'b1; rd_old = idx0_q; end
      PqCtrlSprIdx1:     begin sel_idx1  = 1'b1; rd_old = idx1_q; end
      PqCtrlSprMode:     begin sel_mode  = 1'b1; rd_old = mode_q; end
      PqCtrlSprOmegaIdx: begin sel_omega = 1'b1; rd_old = PQLEN'(omega_idx_o); end
      PqCtrlSprPsiIdx:   begin sel_psi   = 1'b1; rd_old = PQLEN'(psi_idx_o);   end
`ifdef OTBN_PQ_KECCAK_EN
      PqCtrlSprX:        begin sel_x     = 1'b1; rd_old = PQLEN'(x_o);      end
      PqCtrlSprY:        begin sel_y     = 1'b1; rd_old = PQLEN'(y_o);      end
      PqCtrlSprRcIdx:    begin sel_rc    = 1'b1; rd_old = PQLEN'(rc_idx_o); end
`endif
      default: ;
    endcase
  end

  assign mapped    = sel_m | sel_j2 | sel_j | sel_idx0 | sel_idx1 | sel_mode | sel_omega |
                     sel_psi | sel_x | sel_y | sel_rc;
  assign req_any   = ispr_rd_insn_i | ispr_wr_insn_i | ispr_rs_insn_i;
  assign req_multi = (ispr_rd_insn_i & ispr_wr_insn_i) | (ispr_rd_insn_i & ispr_rs_insn_i) |
                     (ispr_wr_insn_i & ispr_rs_insn_i);
  assign ispr_err_o = req_any & (req_multi | ~mapped);

  // Read data stays visible without insn_valid_i so a debugger can peek at the registers.
  assign ispr_rdata_o = ((ispr_rd_insn_i | ispr_rs_insn_i) & ~ispr_err_o) ? rd_old : '0;

  assign wr_en = insn_valid_i & (ispr_wr_insn_i | ispr_rs_insn_i) & ~ispr_err_o;
  assign wval  = ispr_wr_insn_i ? ispr_wdata_i : (rd_old | ispr_wdata_i);

  always_comb begin
    m_d    = m_q;
    j2_d   = j2_q;
    j_d    = j_q;
    idx0_d = idx0_q;
    idx1_d = idx1_q;
    mode_d = mode_q;
    if (sec_wipe_i) begin
      m_d    = '0;
      j2_d   = '0;
      j_d    = '0;
      idx0_d = '0;
      idx1_d = '0;
      mode_d = '0;
    end else begin
      if (wr_en && sel_m)       m_d  = wval;
      else if (upd.sl_m)        m_d  = m_q << 1;
      if (wr_en && sel_j2)      j2_d = wval;
      else if (upd.sl_j2)       j2_d = j2_q << 1;
      if (wr_en && sel_j)       j_d  = wval;
      else if (upd.inc_j)       j_d  = j_q + PQLEN'(1);
      if (wr_en && sel_idx0)    idx0_d = wval;
      else if (upd.set_idx)     idx0_d = j_q;
      else if (upd.inc_idx)     idx0_d = idx0_q + PQLEN'(1);
      if (wr_en && sel_idx1)    idx1_d = wval;
      else if (upd.set_idx)     idx1_d = j_q + j2_q;
      else if (upd.inc_idx)     idx1_d = idx1_q + PQLEN'(1);
      if (wr_en && sel_mode)    mode_d = wval;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q    <= '0;
      j2_q   <= '0;
      j_q    <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
      mode_q <= '0;
    end else begin
      m_q    <= m_d;
      j2_q   <= j2_d;
      j_q    <= j_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      mode_q <= mode_d;
    end
  end

  assign m_o    = m_q;
  assign j2_o   = j2_q;
  assign j_o    = j_q;
  assign idx0_o = idx0_q;
  assign idx1_o = idx1_q;
  assign mode_o = mode_q;

  otbn_pq_ctrlspr_idx_cnt #(.Width(3), .Modulus(8)) u_omega_cnt (
    .clk_i, .rst_ni, .clr_i(sec_wipe_i), .ld_i(wr_en & sel_omega), .ld_val_i(wval[2:0]),
    .en_i(upd.omega_idx_inc), .cnt_o(omega_idx_o)
  );

  otbn_pq_ctrlspr_idx_cnt #(.Width(3), .Modulus(8)) u_psi_cnt (
    .clk_i, .rst_ni, .clr_i(sec_wipe_i), .ld_i(wr_en & sel_psi), .ld_val_i(wval[2:0]),
    .en_i(upd.psi_idx_inc), .cnt_o(psi_idx_o)
  );

`ifdef OTBN_PQ_KECCAK_EN
  otbn_pq_ctrlspr_idx_cnt #(.Width(3), .Modulus(PqKeccakDim)) u_x_cnt (
    .clk_i, .rst_ni, .clr_i(sec_wipe_i), .ld_i(wr_en & sel_x), .ld_val_i(wval[2:0]),
    .en_i(upd.inc_x), .cnt_o(x_o)
  );

  otbn_pq_ctrlspr_idx_cnt #(.Width(3), .Modulus(PqKeccakDim)) u_y_cnt (
    .clk_i, .rst_ni, .clr_i(sec_wipe_i), .ld_i(wr_en & sel_y), .ld_val_i(wval[2:0]),
    .en_i(upd.inc_y), .cnt_o(y_o)
  );

  otbn_pq_ctrlspr_idx_cnt #(.Width(5), .Modulus(PqRcCount)) u_rc_cnt (
    .clk_i, .rst_ni, .clr_i(sec_wipe_i), .ld_i(wr_en & sel_rc), .ld_val_i(wval[4:0]),
    .en_i(upd.rc_idx_inc), .cnt_o(rc_idx_o)
  );
`else
  logic unused_keccak;
  assign unused_keccak = ^{upd.inc_x, upd.inc_y, upd.rc_idx_inc};
  assign x_o      = '0;
  assign y_o      = '0;
  assign rc_idx_o = '0;
`endif

endmodule

// File: tb/tb_otbn_pq_ctrlspr_file.sv
// Directed bench for otbn_pq_ctrlspr_file; Keccak-specific expectations follow OTBN_PQ_KECCAK_EN.
module tb_otbn_pq_ctrlspr_file;

`ifdef OTBN_PQ_KECCAK_EN
  localparam logic K = 1'b1;
`else
  localparam logic K = 1'b0;
`endif

  // upd bit positions
  localparam logic [9:0] U_SLM = 10'h001, U_SLJ2 = 10'h002, U_INCJ = 10'h004, U_INCIDX = 10'h008;
  localparam logic [9:0] U_SETIDX = 10'h010, U_INCX = 10'h020, U_INCY = 10'h040, U_RC = 10'h080;
  localparam logic [9:0] U_OMEGA = 10'h100, U_PSI = 10'h200;
  localparam int O_NONE = 0, O_M = 1, O_J2 = 2, O_J = 3, O_IDX0 = 4, O_IDX1 = 5, O_MODE = 6;
  localparam int O_X = 7, O_Y = 8, O_OMEGA = 9, O_PSI = 10, O_RC = 11;

  logic        clk, rst_n, insn_valid, sec_wipe, rd, wr, rs;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [9:0]  u;
  logic [31:0] rdata, m, j2, j, idx0, idx1, mode;
  logic        err;
  logic [2:0]  x, y, omega, psi;
  logic [4:0]  rc;

  int n_chk = 0;
  int n_fail = 0;

  otbn_pq_ctrlspr_file #(.PQLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .insn_valid_i(insn_valid), .sec_wipe_i(sec_wipe),
    .ispr_addr_i(addr), .ispr_wdata_i(wdata),
    .ispr_rd_insn_i(rd), .ispr_wr_insn_i(wr), .ispr_rs_insn_i(rs),
    .sl_m_i(u[0]), .sl_j2_i(u[1]), .inc_j_i(u[2]), .inc_idx_i(u[3]), .set_idx_i(u[4]),
    .inc_x_i(u[5]), .inc_y_i(u[6]), .rc_idx_inc_i(u[7]), .omega_idx_inc_i(u[8]),
    .psi_idx_inc_i(u[9]),
    .ispr_rdata_o(rdata), .ispr_err_o(err),
    .m_o(m), .j2_o(j2), .j_o(j), .idx0_o(idx0), .idx1_o(idx1), .mode_o(mode),
    .x_o(x), .y_o(y), .omega_idx_o(omega), .psi_idx_o(psi), .rc_idx_o(rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, rd, wr, rs;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [9:0]  upd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          osel;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] get_out(input int s);
    case (s)
      O_M:     return m;
      O_J2:    return j2;
      O_J:     return j;
      O_IDX0:  return idx0;
      O_IDX1:  return idx1;
      O_MODE:  return mode;
      O_X:     return {29'd0, x};
      O_Y:     return {29'd0, y};
      O_OMEGA: return {29'd0, omega};
      O_PSI:   return {29'd0, psi};
      O_RC:    return {27'd0, rc};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic r, input logic w, input logic s,
                     input logic [7:0] a, input logic [31:0] wd, input logic [9:0] up,
                     input logic [31:0] er, input logic ee, input int os, input logic [31:0] eo);
    vec_t t;
    t.v = v; t.rd = r; t.wr = w; t.rs = s; t.addr = a; t.wdata = wd; t.upd = up;
    t.exp_rdata = er; t.exp_err = ee; t.osel = os; t.exp_out = eo;
    vq.push_back(t);
  endtask

  task automatic idle();
    insn_valid = 1'b0; sec_wipe = 1'b0; rd = 1'b0; wr = 1'b0; rs = 1'b0;
    addr = 8'h00; wdata = 32'h0; u = 10'h0;
  endtask

  task automatic run_vec(input vec_t t, input int i);
    @(negedge clk);
    insn_valid = t.v; rd = t.rd; wr = t.wr; rs = t.rs;
    addr = t.addr; wdata = t.wdata; u = t.upd;
    #1;
    check($sformatf("vec%0d rdata", i), rdata, t.exp_rdata);
    check($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, t.exp_err});
    @(posedge clk);
    #1;
    if (t.osel != O_NONE) check($sformatf("vec%0d out%0d", i, t.osel), get_out(t.osel), t.exp_out);
  endtask

  initial begin
    logic [7:0] maddr [11];
    maddr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h60, 8'h70, 8'hB0};

    // reset reads: Keccak addresses error out when the feature is absent
    foreach (maddr[k])
      add(1, 1, 0, 0, maddr[k], 0, 0, 0,
          (maddr[k] == 8'h06 || maddr[k] == 8'h07 || maddr[k] == 8'hB0) ? !K : 1'b0, O_NONE, 0);
    add(1, 0, 1, 0, 8'h02, 32'd3, 0, 0, 0, O_J, 32'd3);
    add(1, 0, 1, 0, 8'h01, 32'd8, 0, 0, 0, O_J2, 32'd8);
    add(1, 0, 0, 0, 8'h00, 0, U_SETIDX, 0, 0, O_IDX0, 32'd3);
    add(1, 1, 0, 0, 8'h04, 0, U_INCIDX | U_INCJ, 32'd11, 0, O_IDX1, 32'd12);
    add(1, 1, 0, 0, 8'h03, 0, 0, 32'd4, 0, O_J, 32'd4);
    add(1, 0, 1, 0, 8'h06, 32'd4, 0, 0, !K, O_X, K ? 32'd4 : 32'd0);
    add(1, 0, 0, 0, 8'h00, 0, U_INCX, 0, 0, O_X, 32'd0);
    add(1, 0, 1, 0, 8'hB0, 32'd23, 0, 0, !K, O_RC, K ? 32'd23 : 32'd0);
    add(1, 0, 0, 0, 8'h00, 0, U_RC, 0, 0, O_RC, 32'd0);
    add(1, 0, 1, 0, 8'hB0, 32'd22, 0, 0, !K, O_NONE, 0);
    add(1, 0, 0, 0, 8'h00, 0, U_RC, 0, 0, O_RC, K ? 32'd23 : 32'd0);
    add(1, 0, 1, 0, 8'h60, 32'd1, 0, 0, 0, O_OMEGA, 32'd1);
    for (int k = 2; k <= 8; k++) add(1, 0, 0, 0, 8'h00, 0, U_OMEGA, 0, 0, O_OMEGA, 32'(k % 8));
    add(1, 0, 1, 0, 8'h00, 32'd2, 0, 0, 0, O_M, 32'd2);
    add(1, 0, 1, 0, 8'h07, 32'd1, 0, 0, !K, O_Y, K ? 32'd1 : 32'd0);
    add(1, 0, 1, 0, 8'h00, 32'h10, U_SLM | U_INCY | U_SLJ2, 0, 0, O_M, 32'h10);
    add(1, 1, 0, 0, 8'h07, 0, 0, K ? 32'd2 : 32'd0, !K, O_J2, 32'd16);
    add(1, 1, 0, 0, 8'h00, 0, 0, 32'h10, 0, O_M, 32'h10);
    add(1, 0, 1, 0, 8'h05, 32'h5, 0, 0, 0, O_MODE, 32'h5);
    add(1, 0, 0, 1, 8'h05, 32'hA, 0, 32'h5, 0, O_MODE, 32'hF);
    add(1, 1, 0, 0, 8'h08, 0, 0, 0, 1, O_MODE, 32'hF);
    add(1, 0, 1, 0, 8'h08, 32'h1234, 0, 0, 1, O_M, 32'h10);
    add(1, 1, 1, 0, 8'h05, 32'h0, 0, 0, 1, O_MODE, 32'hF);
    add(1, 0, 1, 1, 8'h00, 32'h1, 0, 0, 1, O_M, 32'h10);
    add(0, 0, 1, 0, 8'h00, 32'h55, U_SLM, 0, 0, O_M, 32'h10);
    add(0, 1, 0, 0, 8'h00, 0, 0, 32'h10, 0, O_NONE, 0);
    add(1, 0, 0, 0, 8'h00, 0, U_PSI, 0, 0, O_PSI, 32'd1);
    add(1, 0, 1, 0, 8'h70, 32'hFF, 0, 0, 0, O_PSI, 32'd7);
    add(1, 1, 0, 0, 8'h70, 0, U_PSI, 32'd7, 0, O_PSI, 32'd0);
    add(1, 0, 0, 0, 8'h00, 0, U_INCIDX, 0, 0, O_IDX0, 32'd5);
    add(1, 0, 0, 0, 8'h00, 0, U_SETIDX | U_INCIDX, 0, 0, O_IDX0, 32'd4);
    add(1, 1, 0, 0, 8'h04, 0, 0, 32'd20, 0, O_IDX1, 32'd20);
    add(1, 0, 1, 0, 8'h03, 32'h99, U_SETIDX, 0, 0, O_IDX0, 32'h99);
    add(1, 0, 1, 0, 8'h02, 32'hFFFF_FFFF, 0, 0, 0, O_J, 32'hFFFF_FFFF);
    add(1, 0, 0, 0, 8'h00, 0, U_INCJ, 0, 0, O_J, 32'd0);
    add(1, 0, 1, 0, 8'h00, 32'h8000_0000, 0, 0, 0, O_M, 32'h8000_0000);
    add(1, 0, 0, 0, 8'h00, 0, U_SLM, 0, 0, O_M, 32'd0);
    add(1, 0, 1, 0, 8'h01, 32'h8000_0001, 0, 0, 0, O_NONE, 0);
    add(1, 0, 0, 0, 8'h00, 0, U_SLJ2, 0, 0, O_J2, 32'd2);
    add(1, 0, 0, 1, 8'h06, 32'h3, 0, 0, !K, O_X, K ? 32'd3 : 32'd0);
    add(1, 0, 0, 1, 8'h06, 32'h4, 0, K ? 32'd3 : 32'd0, !K, O_X, K ? 32'd7 : 32'd0);
    add(1, 0, 0, 0, 8'h00, 0, U_INCX, 0, 0, O_X, 32'd0);

    idle();
    rst_n = 1'b0;
    #12;
    foreach (maddr[k]) check($sformatf("reset out%0d", k + 1), get_out(k + 1), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // wipe beats a simultaneous write and auto-update
    @(negedge clk);
    insn_valid = 1'b1; sec_wipe = 1'b1; wr = 1'b1; rd = 1'b0; rs = 1'b0;
    addr = 8'h05; wdata = 32'h77; u = U_SLJ2 | U_OMEGA | U_INCJ;
    @(posedge clk);
    #1;
    for (int s = 1; s <= 11; s++) check($sformatf("wipe out%0d", s), get_out(s), 32'd0);

    // async reset mid-cycle, then first commit starts from zero
    @(negedge clk);
    idle();
    insn_valid = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 32'h33;
    @(posedge clk);
    #1;
    check("pre-rst m", m, 32'h33);
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst m", m, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    insn_valid = 1'b1; u = U_INCJ | U_OMEGA;
    @(posedge clk);
    #1;
    check("post-rst j", j, 32'd1);
    check("post-rst omega", {29'd0, omega}, 32'd1);
    @(negedge clk);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/otbn_pq_ctrlspr_file.md
# otbn_pq_ctrlspr_file

Register file for the PQ control special-purpose registers. It answers the control-SPR read, write and read-set requests raised by the PQ decoder, and applies the decoder's autonomous loop-counter updates. Those updates cover the NTT indices, Keccak lane coordinates, and the round-constant and twiddle indices. It sits in the PQ execute stage next to the PQ ALU and feeds current index values back to the datapath and the controller.

## Interface
- `PQLEN`, 32: data width of wide control registers (M, J2, J, Idx0, Idx1, Mode).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `insn_valid_i`  in  1  commit strobe; no state changes without it.
- `sec_wipe_i`  in  1  synchronous wipe of all registers to reset values.
- `ispr_addr_i`  in  8  control-SPR address (`pqctrlspr_e`).
- `ispr_wdata_i`  in  PQLEN  write / set data.
- `ispr_rd_insn_i`, `ispr_wr_insn_i`, `ispr_rs_insn_i`  in  1 each  read, write, read-set request.
- `sl_m_i`, `sl_j2_i`, `inc_j_i`, `inc_idx_i`, `set_idx_i`  in  1 each  NTT loop updates.
- `inc_x_i`, `inc_y_i`, `rc_idx_inc_i`, `omega_idx_inc_i`, `psi_idx_inc_i`  in  1 each  index updates.
- `ispr_rdata_o`  out  PQLEN  read data, zero-extended.
- `ispr_err_o`  out  1  illegal access.
- `m_o`, `j2_o`, `j_o`, `idx0_o`, `idx1_o`, `mode_o`  out  PQLEN  register values.
- `x_o`, `y_o`, `omega_idx_o`, `psi_idx_o`  out  3; `rc_idx_o`  out  5  register values.

## Operation
- Mapped addresses: 0x00 M, 0x01 J2, 0x02 J, 0x03 Idx0, 0x04 Idx1, 0x05 Mode, 0x06 X, 0x07 Y, 0x60 OmegaIdx, 0x70 PsiIdx, 0xB0 RcIdx. All other addresses are unmapped.
- Read and read-set return the current (old) value on `ispr_rdata_o` combinationally. `ispr_rdata_o` is 0 when no read is active.
- Write stores `ispr_wdata_i`; read-set stores `old | ispr_wdata_i`. Narrow registers keep only the low bits.
- `ispr_err_o` is combinational and raised when either:
  - any request targets an unmapped address, or
  - more than one of rd/wr/rs is asserted.
  When raised, rdata is 0 and nothing is written.
- Updates:
  - `sl_m`: M <<= 1. `sl_j2`: J2 <<= 1. `inc_j`: J += 1. All wrap mod 2^PQLEN.
  - `inc_idx`: Idx0 += 1 and Idx1 += 1.
  - `set_idx`: Idx0 = J and Idx1 = J + J2, using pre-update J and J2.
  - X, Y: next = (v >= 4) ? 0 : v+1.
  - RcIdx: next = (v >= 23) ? 0 : v+1.
  - OmegaIdx, PsiIdx: +1 mod 8.
- Simultaneous events:
  - An explicit wr/rs to a register wins over any auto-update of that same register. Other registers still update.
  - `set_idx` wins over `inc_idx`.
  - `sec_wipe_i` wins over everything.

## Timing
- Reset: every register and every output is 0 (`ispr_rdata_o` = 0, `ispr_err_o` = 0).
- Writes and updates commit on the rising edge when `insn_valid_i` = 1. Register outputs show the new value in the following cycle.
- Read data is valid in the same cycle as the request. A read in the cycle after a write returns the written value.
- Reset asserted mid-sequence clears all state asynchronously. The first commit after deassertion sees zeros.
- Request inputs are ignored when `insn_valid_i` = 0. Read data is still driven for debug visibility.

## Configuration
- `OTBN_PQ_KECCAK_EN` defined: X, Y and RcIdx exist as specified.
- Undefined: those three registers are removed and their outputs are tied to 0. Addresses 0x06, 0x07 and 0xB0 become unmapped (error), and `inc_x`, `inc_y`, `rc_idx_inc` are ignored.

## Structure
- `otbn_pq_pkg` holds:
  - `pqctrlspr_e` and `PqctrlsprNumWidth`;
  - new constants `PqKeccakDim` = 5 and `PqRcCount` = 24;
  - new struct `pqctrlspr_upd_t` bundling the ten update strobes.
- Sub-module `otbn_pq_ctrlspr_idx_cnt`: a wrapping index counter with parameters width and modulus, and ports for enable, load and clear. It is instantiated for X, Y, RcIdx, OmegaIdx and PsiIdx.

## Test plan
- Reset release, then read every mapped address → rdata 0, err 0.
- Write J = 3 and J2 = 8, then `set_idx` → Idx0 = 3, Idx1 = 11. Next, `inc_idx` + `inc_j` → Idx0 = 4, Idx1 = 12, J = 4.
- Write X = 4, then `inc_x` → X = 0. Write RcIdx = 23, then `rc_idx_inc` → 0. Seven `omega_idx_inc` from 1 → 0.
- Same cycle: wr M = 0x10 and `sl_m` with M = 2 → M = 0x10. `inc_y` in that cycle still increments Y.
- Read-set Mode = 0x5 with wdata 0xA → rdata 0x5, then Mode = 0xF. Access to 0x08, or rd+wr together → err 1, no state change.
- With `OTBN_PQ_KECCAK_EN` undefined: write 0x06 → err 1, and `x_o` stays 0 after `inc_x`.
